ysyx_23060208_ifu_prefetch: RTL and testbench
=============================================

# ysyx_23060208_ifu_prefetch

Parametrised next-generation instruction fetch unit with an in-order prefetch queue. It sits between the EXU redirect path, the instruction memory port and the IDU. It keeps up to `FIFO_DEPTH` fetches in flight or buffered, and tags each returned instruction with its PC. On an EXU redirect it flushes buffered instructions and discards stale in-flight responses.

## Interface
- `DATA_WIDTH`, 32 — PC and instruction width.
- `FIFO_DEPTH`, 4 — prefetch queue depth; power of two, ≥2; also the cap on buffered plus outstanding fetches.
- `RESET_PC`, 32'h8000_0000 — first fetch address after reset.

- `clk` in 1 — the single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `redirect_valid` in 1 — EXU redirect strobe, single cycle.
- `redirect_pc` in DATA_WIDTH — redirect target; bits [1:0] treated as 0.
- `imem_req_valid` out 1 — fetch request valid.
- `imem_req_ready` in 1 — memory accepts request.
- `imem_req_addr` out DATA_WIDTH — fetch address, word aligned.
- `imem_resp_valid` in 1 — response valid; responses return in request order, always accepted.
- `imem_resp_data` in DATA_WIDTH — fetched instruction.
- `ifu_to_idu_valid` out 1 — head of queue valid.
- `ifu_to_idu_pc` out DATA_WIDTH — PC of head entry.
- `ifu_to_idu_inst` out DATA_WIDTH — instruction of head entry.
- `idu_allowin` in 1 — IDU consumes head this cycle when `ifu_to_idu_valid` is high.
- `perf_fetch_cnt` out 32 — present only with `IFU_PF_PERF_EN`.
- `perf_drop_cnt` out 32 — present only with `IFU_PF_PERF_EN`.

## Operation
- **Registers**
  - `fpc`: next fetch address.
  - `rpc`: PC of next non-stale response.
  - `cnt`: queue occupancy, 0..DEPTH.
  - `outst`: accepted but unreturned requests.
  - `drop`: stale responses still to discard.
  - Counter widths are clog2(DEPTH)+1.
- **Request issue:** `imem_req_valid = !redirect_valid && (cnt + outst < FIFO_DEPTH)`. `imem_req_addr = fpc`.
- **Request handshake** (valid & ready): `fpc += 4`, `outst += 1`.
- **Response handling**
  - A response with `drop > 0` is discarded: `drop -= 1`, `outst -= 1`.
  - Otherwise it is written as `{rpc, data}` at the queue tail: `rpc += 4`, `outst -= 1`, `cnt += 1`.
- **Queue:** circular buffer with wrap-around read/write pointers. Head is driven combinationally from storage. Pop when `ifu_to_idu_valid && idu_allowin`.
- **Redirect** (highest priority)
  - Sets `fpc <= redirect_pc`, `rpc <= redirect_pc`, `cnt <= 0`, and resets the pointers.
  - Sets `drop <= outst - (imem_resp_valid ? 1 : 0)`; the same-cycle response is discarded.
  - No request is issued in the redirect cycle.
  - A same-cycle IDU handshake counts as a consumed head.
- **Simultaneous push and pop:** when the queue is full, push and pop in the same cycle is legal and `cnt` is unchanged. Push never occurs when full, because credits guarantee it.
- **Protocol violation:** `imem_resp_valid` with `outst == 0` is ignored. The bench asserts this never happens.
- **Reset values**
  - `fpc = rpc = RESET_PC`.
  - `cnt = outst = drop = 0`; pointers 0.
  - `ifu_to_idu_valid = 0`.
  - `imem_req_valid` is held 0 while `rst` is high.
  - Perf counters 0.
  - Queue storage contents are don't-care.

## Timing
- `rst` deassert → `imem_req_valid = 1` with addr `RESET_PC` in the first following cycle.
- Response accepted in cycle N → `ifu_to_idu_valid` high in N+1; there is no bypass.
- A pop in cycle N frees its credit, and a new request may issue in N+1.
- Redirect in cycle N:
  - `ifu_to_idu_valid = 0` in N+1.
  - First request to the new target issues in N+1.
  - The first new instruction is visible no earlier than the cycle after its response, once all `drop` responses have drained.
- Reset asserted mid-operation clears all state immediately; outstanding memory responses after reset are the memory's responsibility to squash.
- Throughput with zero-latency memory and `idu_allowin` held high is 1 instruction per cycle.

## Configuration
- `IFU_PF_PERF_EN` defined:
  - Adds `perf_fetch_cnt`, which increments on each request handshake.
  - Adds `perf_drop_cnt`, which increments on each discarded response and on each entry flushed by a redirect, by `cnt` in that cycle.
  - Both counters saturate at 32'hFFFF_FFFF.
- `IFU_PF_PERF_EN` undefined: the ports and logic are absent, and behaviour is otherwise identical.

## Test plan
- **Reset and stream:** `FIFO_DEPTH=4`, memory returns 1 cycle after each request, `idu_allowin=1` → IDU sees PCs 0x80000000, 0x80000004, 0x80000008… one per cycle after the pipeline fills.
- **Backpressure:** `idu_allowin=0` → exactly 4 requests issued, `cnt=4`, `imem_req_valid=0`. Raise `idu_allowin` for one cycle → one pop, one new request at 0x80000010.
- **Redirect with in-flight fetches:** memory latency 3, two requests outstanding, redirect to 0x80001000 → the two old responses are discarded, and the next IDU entry is PC 0x80001000 with the matching data.
- **Redirect coinciding with a response and an IDU pop:** the response is discarded, the queue is empty the next cycle, and `drop = outst - 1`.
- **Wrap-around:** push and pop 11 entries through depth 4 with random `idu_allowin` → PCs stay strictly sequential, with no loss or duplication.
- **With `IFU_PF_PERF_EN`:** scenario 3 gives `perf_drop_cnt = 2 + cnt_at_redirect`, and `perf_fetch_cnt` equals the number of request handshakes.

Source files
------------

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// Instruction fetch unit with an in-order, credit-limited prefetch queue between imem and the IDU.
// Define IFU_PF_PERF_EN to add saturating fetch and drop performance counters.
module ysyx_23060208_ifu_prefetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  ifu_to_idu_valid,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
  input  logic                  idu_allowin
`ifdef IFU_PF_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_drop_cnt
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_fpc;
  logic [DATA_WIDTH-1:0] r_rpc;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_outst;
  logic [CW-1:0]         r_drop;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_pc_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_inst_mem [FIFO_DEPTH];

  logic [CW:0]           w_used;
  logic                  w_req_hs;
  logic                  w_resp;
  logic                  w_discard;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_hs_inc;
  logic [CW-1:0]         w_resp_dec;
  logic [CW-1:0]         w_push_inc;
  logic [CW-1:0]         w_pop_dec;
  logic [DATA_WIDTH-1:0] w_redirect_pc;

  // Buffered plus in-flight fetches never exceed the queue depth, so a response always has a slot.
  assign w_used         = {1'b0, r_cnt} + {1'b0, r_outst};
  assign imem_req_valid = !rst && !redirect_valid && (w_used < DEPTH_W);
  assign imem_req_addr  = r_fpc;

  assign w_req_hs   = imem_req_valid && imem_req_ready;
  assign w_resp     = imem_resp_valid && (r_outst != '0);
  assign w_discard  = w_resp && (r_drop != '0);
  assign w_push     = w_resp && (r_drop == '0) && !redirect_valid;
  assign w_pop      = ifu_to_idu_valid && idu_allowin;

  assign w_hs_inc   = w_req_hs ? CW'(1) : CW'(0);
  assign w_resp_dec = w_resp   ? CW'(1) : CW'(0);
  assign w_push_inc = w_push   ? CW'(1) : CW'(0);
  assign w_pop_dec  = w_pop    ? CW'(1) : CW'(0);

  assign w_redirect_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

  assign ifu_to_idu_valid = (r_cnt != '0);
  assign ifu_to_idu_pc    = r_pc_mem[r_rptr];
  assign ifu_to_idu_inst  = r_inst_mem[r_rptr];

  // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc   <= RESET_PC;
      r_rpc   <= RESET_PC;
      r_cnt   <= '0;
      r_outst <= '0;
      r_drop  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path, including nothing issued this cycle.
      r_fpc   <= w_redirect_pc;
      r_rpc   <= w_redirect_pc;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_outst <= r_outst - w_resp_dec;
      r_drop  <= r_outst - w_resp_dec;
    end else begin
      if (w_req_hs) r_fpc <= r_fpc + DATA_WIDTH'(4);
      if (w_push) begin
        r_rpc  <= r_rpc + DATA_WIDTH'(4);
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_discard) r_drop <= r_drop - CW'(1);
      r_cnt   <= r_cnt + w_push_inc - w_pop_dec;
      r_outst <= r_outst + w_hs_inc - w_resp_dec;
    end
  end

  // NOTE: queue storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= r_rpc;
      r_inst_mem[r_wptr] <= imem_resp_data;
    end
  end

`ifdef IFU_PF_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_drop;
  logic        w_resp_lost;
  logic [CW:0] w_drop_inc;
  logic [32:0] w_fetch_sum;
  logic [32:0] w_drop_sum;

  // A redirect counts every buffered entry plus a response arriving in the same cycle.
  assign w_resp_lost = w_resp && (redirect_valid || (r_drop != '0));
  assign w_drop_inc  = (redirect_valid ? {1'b0, r_cnt} : '0) + {{CW{1'b0}}, w_resp_lost};
  assign w_fetch_sum = {1'b0, r_perf_fetch} + {32'b0, w_req_hs};
  assign w_drop_sum  = {1'b0, r_perf_drop} + 33'(w_drop_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
    end else begin
      r_perf_fetch <= w_fetch_sum[32] ? 32'hFFFF_FFFF : w_fetch_sum[31:0];
      r_perf_drop  <= w_drop_sum[32]  ? 32'hFFFF_FFFF : w_drop_sum[31:0];
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
`endif

endmodule

// File: tb/tb_ysyx_23060208_ifu_prefetch.sv
// Self-checking bench for ysyx_23060208_ifu_prefetch: directed table, corner sequences and a
// randomized run against a queue-based reference model; IFU_PF_PERF_EN also checks the counters.
module tb_ysyx_23060208_ifu_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        ifu_to_idu_valid;
  logic [31:0] ifu_to_idu_pc;
  logic [31:0] ifu_to_idu_inst;
  logic        idu_allowin = 1'b0;
`ifdef IFU_PF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] m_perf_fetch;
  logic [31:0] m_perf_drop;
`endif

  ysyx_23060208_ifu_prefetch #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .ifu_to_idu_pc    (ifu_to_idu_pc),
    .ifu_to_idu_inst  (ifu_to_idu_inst),
    .idu_allowin      (idu_allowin)
`ifdef IFU_PF_PERF_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_drop_cnt    (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; bit stale; } fly_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct {
    logic        aw;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  mreq_t mem_q[$];
  fly_t  m_fly[$];
  ent_t  m_buf[$];
  logic [31:0] m_fpc;
  int lat = 1;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_pops = 0;

  logic        a_req;
  logic [31:0] a_addr;
  logic        a_iv;
  logic [31:0] a_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs with the model, advance both.
  task automatic step(input logic rv, input logic [31:0] tgt, input logic rdy, input logic aw);
    logic e_req;
    logic resp;
    int   n0;
    fly_t f;
    fly_t nf;
    ent_t e;
    redirect_valid = rv;
    redirect_pc    = tgt;
    imem_req_ready = rdy;
    idu_allowin    = aw;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_data(mem_q[0].addr) : 32'h0;
    #1;
    a_req  = imem_req_valid;
    a_addr = imem_req_addr;
    a_iv   = ifu_to_idu_valid;
    a_pc   = ifu_to_idu_pc;

    n0    = m_buf.size();
    e_req = !rv && ((m_buf.size() + m_fly.size()) < DEPTH);
    check("req_valid", 32'(a_req), 32'(e_req));
    if (e_req && a_req) check("req_addr", a_addr, m_fpc);
    check("idu_valid", 32'(a_iv), 32'(n0 > 0));
    if (n0 > 0 && a_iv) begin
      check("idu_pc", a_pc, m_buf[0].pc);
      check("idu_inst", ifu_to_idu_inst, m_buf[0].inst);
    end
    if (resp) check("resp_has_outstanding", 32'(m_fly.size() > 0), 32'd1);
`ifdef IFU_PF_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_perf_fetch);
    check("perf_drop", perf_drop_cnt, m_perf_drop);
`endif

    if (a_iv && aw) n_pops++;
    if (n0 > 0 && aw) m_buf.delete(0);
    if (resp && m_fly.size() > 0) begin
      f = m_fly.pop_front();
      if (!f.stale && !rv) begin
        e.pc   = f.addr;
        e.inst = mem_data(f.addr);
        m_buf.push_back(e);
      end
`ifdef IFU_PF_PERF_EN
      else m_perf_drop = m_perf_drop + 32'd1;
`endif
    end
    if (rv) begin
`ifdef IFU_PF_PERF_EN
      m_perf_drop = m_perf_drop + 32'(n0);
`endif
      m_buf.delete();
      foreach (m_fly[i]) m_fly[i].stale = 1'b1;
      m_fpc = {tgt[31:2], 2'b00};
    end
    if (e_req && rdy) begin
      nf.addr  = m_fpc;
      nf.stale = 1'b0;
      m_fly.push_back(nf);
      m_fpc = m_fpc + 32'd4;
`ifdef IFU_PF_PERF_EN
      m_perf_fetch = m_perf_fetch + 32'd1;
`endif
    end

    if (resp) mem_q.delete(0);
    if (a_req && rdy) begin
      mreq_t m;
      m.addr = a_addr;
      m.due  = cyc + lat;
      mem_q.push_back(m);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    idu_allowin     = 1'b0;
    mem_q.delete();
    m_buf.delete();
    m_fly.delete();
    m_fpc = RESET_PC;
`ifdef IFU_PF_PERF_EN
    m_perf_fetch = '0;
    m_perf_drop  = '0;
`endif
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_idu_valid", 32'(ifu_to_idu_valid), 32'd0);
`ifdef IFU_PF_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idu(input string name, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      seen = a_iv;
    end
    check({name, "_timeout"}, 32'(seen), 32'd1);
  endtask

  vec_t vt[10];

  initial begin
    int  n_valid;
    bit  seen;
    vt[0] = '{1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
    vt[3] = '{1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0000};
    vt[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
    vt[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
    vt[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
    vt[7] = '{1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0004};
    vt[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004};
    vt[9] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004};

    // Backpressure: queue fills to depth, one pop frees exactly one credit.
    lat = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1, vt[i].aw);
      check("tbl_req_valid", 32'(a_req), 32'(vt[i].e_req));
      if (vt[i].e_req) check("tbl_req_addr", a_addr, vt[i].e_addr);
      check("tbl_idu_valid", 32'(a_iv), 32'(vt[i].e_iv));
      if (vt[i].e_iv) check("tbl_idu_pc", a_pc, vt[i].e_pc);
    end

    // Streaming at one instruction per cycle once the pipeline fills.
    lat = 1;
    do_reset();
    n_valid = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (i == 2) check("stream_first_pc", a_pc, RESET_PC);
      if (a_iv) n_valid++;
    end
    check("stream_throughput", 32'(n_valid), 32'd38);

    // Redirect with two fetches in flight at latency 3.
    lat = 3;
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h8000_1000, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("redir_idu_empty", 32'(a_iv), 32'd0);
    check("redir_req_addr", a_addr, 32'h8000_1000);
    wait_idu("redir", 20, seen);
    check("redir_first_pc", a_pc, 32'h8000_1000);
    check("redir_first_inst", ifu_to_idu_inst, mem_data(32'h8000_1000));
`ifdef IFU_PF_PERF_EN
    check("redir_perf_drop", perf_drop_cnt, 32'd2);
`endif

    // Redirect in the same cycle as a response and an IDU pop.
    lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h8000_2003, 1'b1, 1'b1);
    check("coinc_popped_head", 32'(a_iv), 32'd1);
    check("coinc_drop", 32'(dut.r_drop), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("coinc_idu_empty", 32'(a_iv), 32'd0);
    check("coinc_req_addr", a_addr, 32'h8000_2000);
    wait_idu("coinc", 20, seen);
    check("coinc_first_pc", a_pc, 32'h8000_2000);

    // Wrap-around: 11 entries through the depth-4 queue with random IDU backpressure.
    lat = 1;
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 300 && n_pops < 11; i++)
      step(1'b0, 32'h0, 1'b1, 1'($urandom_range(0, 1)));
    check("wrap_pops", 32'(n_pops >= 11), 32'd1);

    // Randomized traffic with redirects, latency changes and a mid-run reset.
    lat = 2;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = int'($urandom_range(1, 4));
      if (i == 700) do_reset();
      step(1'($urandom_range(0, 99) < 3), $urandom,
           1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
